// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and helpers for the UART buffer path FIFOs.
// Revision    : 1.0 - initial parametrised FIFO release
// ============================================================================
package uart_pkg;

    localparam int c_default_data_w = 8;
    localparam int c_default_depth  = 16;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram
// Description : Simple dual-port RAM, synchronous write, async or registered read.
// Revision    : 1.0 - initial parametrised FIFO release
// ============================================================================
module fifo_ram
    import uart_pkg::*;
#(
    parameter int DATA_W  = c_default_data_w,
    parameter int DEPTH   = c_default_depth,
    parameter int REG_OUT = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clr,
    input  logic                      wr_en,
    input  logic [clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    input  logic [clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]         rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] w_rd_async;

    // Storage is deliberately left unreset so it maps onto RAM macros.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign w_rd_async = r_mem[rd_addr];

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [DATA_W-1:0] r_rd_data;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_rd_data <= '0;
                end else if (clr) begin
                    r_rd_data <= '0;
                end else if (rd_en) begin
                    r_rd_data <= w_rd_async;
                end
            end

            assign rd_data = r_rd_data;
        end else begin : g_async
            logic w_unused;
            assign w_unused = &{1'b0, reset_n, clr, rd_en};
            assign rd_data  = w_rd_async;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/uart_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_sync
// Description : Parametrised synchronous FIFO with flags, count, errors, flush, FWFT.
// Revision    : 1.0 - initial parametrised FIFO release
// ============================================================================
module uart_fifo_sync
    import uart_pkg::*;
#(
    parameter int DATA_W    = c_default_data_w,
    parameter int DEPTH     = c_default_depth,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = MODE_STD
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       din,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       dout,
    output logic                    dout_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int c_addr_w = clog2(DEPTH);
    localparam logic [c_addr_w:0] c_depth_cnt = (c_addr_w + 1)'(DEPTH);
    localparam logic [c_addr_w:0] c_af_thresh = (c_addr_w + 1)'(AF_THRESH);
    localparam logic [c_addr_w:0] c_ae_thresh = (c_addr_w + 1)'(AE_THRESH);
    localparam logic [c_addr_w:0] c_one       = (c_addr_w + 1)'(1);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
            $error("uart_fifo_sync: DEPTH must be a power of two >= 2");
        end
        if (AF_THRESH > DEPTH) begin : g_chk_af
            $error("uart_fifo_sync: AF_THRESH must be <= DEPTH");
        end
        if (AE_THRESH >= DEPTH) begin : g_chk_ae
            $error("uart_fifo_sync: AE_THRESH must be < DEPTH");
        end
    endgenerate

    logic [c_addr_w:0]  r_wr_ptr;
    logic [c_addr_w:0]  r_rd_ptr;
    logic [c_addr_w:0]  r_count;
    logic               r_overflow;
    logic               r_underflow;
    logic               w_full;
    logic               w_empty;
    logic               w_rd_acc;
    logic               w_wr_acc;
    logic [DATA_W-1:0]  w_ram_data;
    logic               w_unused;

    assign w_full   = (r_count == c_depth_cnt);
    assign w_empty  = (r_count == '0);
    assign w_rd_acc = rd_en & ~w_empty;
    // A full FIFO still takes a write when the same cycle frees a slot.
    assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_one;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_one;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + c_one;
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - c_one;
            end
            r_overflow  <= wr_en & ~w_wr_acc;
            r_underflow <= rd_en & w_empty;
        end
    end

    fifo_ram #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .REG_OUT ((FWFT == MODE_FWFT) ? 0 : 1)
    ) u_fifo_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .wr_en   (w_wr_acc & ~clr),
        .wr_addr (r_wr_ptr[c_addr_w-1:0]),
        .wr_data (din),
        .rd_en   (w_rd_acc & ~clr),
        .rd_addr (r_rd_ptr[c_addr_w-1:0]),
        .rd_data (w_ram_data)
    );

    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            assign dout_valid = ~w_empty;
        end else begin : g_std
            logic r_dout_valid;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_dout_valid <= 1'b0;
                end else if (clr) begin
                    r_dout_valid <= 1'b0;
                end else begin
                    r_dout_valid <= w_rd_acc;
                end
            end

            assign dout_valid = r_dout_valid;
        end
    endgenerate

    // Pointer MSBs only matter for wrap tracking; occupancy comes from r_count.
    assign w_unused     = &{1'b0, r_wr_ptr[c_addr_w], r_rd_ptr[c_addr_w]};

    assign dout         = w_ram_data;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_af_thresh);
    assign almost_empty = (r_count <= c_ae_thresh);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_fifo_sync
// Description : Scoreboard bench for standard (8b x 16) and FWFT (12b x 4) FIFOs.
// Revision    : 1.0 - initial parametrised FIFO release
// ============================================================================
module tb_uart_fifo_sync;

    logic        clk;
    logic        reset_n;

    logic        s_clr, s_wr_en, s_rd_en;
    logic [7:0]  s_din, s_dout;
    logic        s_dout_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [4:0]  s_count;

    logic        f_clr, f_wr_en, f_rd_en;
    logic [11:0] f_din, f_dout;
    logic        f_dout_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [2:0]  f_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  q_std [$];
    logic [11:0] q_fwft [$];

    uart_fifo_sync #(
        .DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)
    ) u_std (
        .clk(clk), .reset_n(reset_n), .clr(s_clr), .wr_en(s_wr_en), .din(s_din),
        .rd_en(s_rd_en), .dout(s_dout), .dout_valid(s_dout_valid), .full(s_full),
        .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    uart_fifo_sync #(
        .DATA_W(12), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)
    ) u_fwft (
        .clk(clk), .reset_n(reset_n), .clr(f_clr), .wr_en(f_wr_en), .din(f_din),
        .rd_en(f_rd_en), .dout(f_dout), .dout_valid(f_dout_valid), .full(f_full),
        .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a word.
    always @(negedge clk) begin
        if (reset_n && s_dout_valid) begin
            if (q_std.size() == 0) begin
                n_checks++;
                $display("FAIL std_unexpected: dout=0x%0h with no word expected", s_dout);
            end else begin
                check("std_dout", 32'(s_dout), 32'(q_std.pop_front()));
            end
        end
        if (reset_n && f_rd_en && f_dout_valid) begin
            if (q_fwft.size() == 0) begin
                n_checks++;
                $display("FAIL fwft_unexpected: dout=0x%0h with no word expected", f_dout);
            end else begin
                check("fwft_dout", 32'(f_dout), 32'(q_fwft.pop_front()));
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        s_clr = 0; s_wr_en = 0; s_rd_en = 0; s_din = '0;
        f_clr = 0; f_wr_en = 0; f_rd_en = 0; f_din = '0;
        tick();
        tick();
        check("rst_count", 32'(s_count), 0);
        check("rst_empty", 32'(s_empty), 1);
        check("rst_full", 32'(s_full), 0);
        check("rst_ae", 32'(s_ae), 1);
        check("rst_af", 32'(s_af), 0);
        check("rst_dout", 32'(s_dout), 0);
        check("rst_valid", 32'(s_dout_valid), 0);
        check("rst_fwft_valid", 32'(f_dout_valid), 0);
        reset_n = 1'b1;
        tick();

        // Fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            s_wr_en = 1; s_din = 8'(i);
            tick();
            check("fill_count", 32'(s_count), 32'(i));
            check("fill_af", 32'(s_af), (i >= 14) ? 1 : 0);
            check("fill_ae", 32'(s_ae), (i <= 2) ? 1 : 0);
        end
        s_wr_en = 0;
        check("fill_full", 32'(s_full), 1);

        // Overflow: 0xAA dropped
        s_wr_en = 1; s_din = 8'hAA;
        tick();
        s_wr_en = 0;
        check("ovf_pulse", 32'(s_ovf), 1);
        check("ovf_count", 32'(s_count), 16);
        tick();
        check("ovf_clear", 32'(s_ovf), 0);

        // Simultaneous write+read on full
        s_wr_en = 1; s_rd_en = 1; s_din = 8'h55;
        q_std.push_back(8'h01);
        tick();
        s_wr_en = 0; s_rd_en = 0;
        check("sim_count", 32'(s_count), 16);
        check("sim_no_ovf", 32'(s_ovf), 0);
        check("sim_valid", 32'(s_dout_valid), 1);

        // Drain: 0x02..0x10 then 0x55 across the pointer wrap
        for (int i = 0; i < 16; i++) begin
            s_rd_en = 1;
            q_std.push_back((i < 15) ? 8'(i + 2) : 8'h55);
            tick();
            check("drain_valid", 32'(s_dout_valid), 1);
        end
        s_rd_en = 0;
        check("drain_empty", 32'(s_empty), 1);
        check("drain_count", 32'(s_count), 0);
        tick();
        check("drain_valid_drop", 32'(s_dout_valid), 0);

        // Underflow
        s_rd_en = 1;
        tick();
        s_rd_en = 0;
        check("unf_pulse", 32'(s_unf), 1);
        check("unf_dout_hold", 32'(s_dout), 32'h55);
        check("unf_valid", 32'(s_dout_valid), 0);
        tick();
        check("unf_clear", 32'(s_unf), 0);

        // Flush with count=5 and a concurrent write
        for (int i = 0; i < 5; i++) begin
            s_wr_en = 1; s_din = 8'(8'h31 + i);
            tick();
        end
        check("pre_clr_count", 32'(s_count), 5);
        s_clr = 1; s_wr_en = 1; s_din = 8'h77;
        tick();
        s_clr = 0; s_wr_en = 0;
        check("clr_count", 32'(s_count), 0);
        check("clr_empty", 32'(s_empty), 1);
        check("clr_ae", 32'(s_ae), 1);
        check("clr_no_ovf", 32'(s_ovf), 0);
        check("clr_dout", 32'(s_dout), 0);
        s_wr_en = 1; s_din = 8'h99;
        tick();
        s_wr_en = 0; s_rd_en = 1;
        q_std.push_back(8'h99);
        tick();
        s_rd_en = 0;
        check("post_clr_valid", 32'(s_dout_valid), 1);
        tick();
        check("post_clr_empty", 32'(s_empty), 1);

        // Async reset mid-burst
        for (int i = 0; i < 7; i++) begin
            s_wr_en = 1; s_din = 8'(8'h41 + i);
            tick();
        end
        s_wr_en = 0;
        check("pre_rst_count", 32'(s_count), 7);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_count", 32'(s_count), 0);
        check("arst_empty", 32'(s_empty), 1);
        check("arst_ae", 32'(s_ae), 1);
        check("arst_dout", 32'(s_dout), 0);
        check("arst_valid", 32'(s_dout_valid), 0);
        tick();
        reset_n = 1'b1;
        s_wr_en = 1; s_din = 8'h61;
        tick();
        s_din = 8'h62;
        tick();
        s_wr_en = 0; s_rd_en = 1;
        q_std.push_back(8'h61);
        tick();
        q_std.push_back(8'h62);
        tick();
        s_rd_en = 0;
        tick();
        check("resume_empty", 32'(s_empty), 1);

        // FWFT: head visible before any rd_en
        f_wr_en = 1; f_din = 12'hABC;
        tick();
        check("fwft_count1", 32'(f_count), 1);
        check("fwft_valid", 32'(f_dout_valid), 1);
        check("fwft_head", 32'(f_dout), 32'hABC);
        check("fwft_ae1", 32'(f_ae), 1);
        f_din = 12'hDEF;
        tick();
        check("fwft_ae2", 32'(f_ae), 0);
        check("fwft_head_hold", 32'(f_dout), 32'hABC);
        f_wr_en = 0; f_rd_en = 1;
        q_fwft.push_back(12'hABC);
        tick();
        q_fwft.push_back(12'hDEF);
        tick();
        f_rd_en = 0;
        check("fwft_empty", 32'(f_empty), 1);
        check("fwft_valid_drop", 32'(f_dout_valid), 0);

        // FWFT fill to full, overflow, drain
        for (int i = 0; i < 4; i++) begin
            f_wr_en = 1; f_din = 12'(12'h101 + i);
            tick();
            check("fwft_af", 32'(f_af), (i >= 2) ? 1 : 0);
        end
        check("fwft_full", 32'(f_full), 1);
        f_din = 12'hEEE;
        tick();
        f_wr_en = 0;
        check("fwft_ovf", 32'(f_ovf), 1);
        check("fwft_ovf_count", 32'(f_count), 4);
        for (int i = 0; i < 4; i++) begin
            f_rd_en = 1;
            q_fwft.push_back(12'(12'h101 + i));
            tick();
        end
        check("fwft_drained", 32'(f_empty), 1);
        tick();
        check("fwft_unf", 32'(f_unf), 1);
        f_rd_en = 0;
        tick();

        check("std_sb_drained", 32'(q_std.size()), 0);
        check("fwft_sb_drained", 32'(q_fwft.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
